cs_dac_i2s_transmitter: RTL and testbench



---
 rtl/cs_dac_i2s_transmitter.sv | 173 +++++++++++++++++
 tb/tb_cs_dac_i2s_transmitter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cs_dac_i2s_transmitter.sv
// cs_dac_i2s_transmitter: stream-to-I2S serializer for the CS4344 DAC.
// Buffers one stereo frame from the mixer and shifts it out as standard
// I2S. SCLK and LRCK are derived from clk. Optional build macro
// DAC_HOLD_ON_UNDERRUN_EN: on underrun, repeat the last transmitted frame
// instead of sending silence.
module cs_dac_i2s_transmitter #(
   parameter int unsigned AUDIO_WIDTH_P = 24,
   parameter int unsigned SLOT_WIDTH_P  = 32,
   parameter int unsigned SCLK_DIV_P    = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [AUDIO_WIDTH_P-1:0] dac_data,
   input  logic                     dac_valid,
   output logic                     dac_ready,
   input  logic                     dac_last,
   input  logic                     cmd_clear_flags,
   output logic                     i2s_sclk,
   output logic                     i2s_lrck,
   output logic                     i2s_sdata,
   output logic                     fs_strobe,
   output logic                     sr_underrun,
   output logic                     sr_sync_err
);

   localparam int unsigned DIV_W   = (SCLK_DIV_P > 2) ? $clog2(SCLK_DIV_P) : 1;
   localparam int unsigned FRAME_W = 2 * SLOT_WIDTH_P;
   localparam int unsigned BIT_W   = $clog2(FRAME_W);
   localparam int unsigned PAD_W   = SLOT_WIDTH_P - AUDIO_WIDTH_P;

   typedef enum logic [1:0] {
      WAIT_LEFT  = 2'd0,
      WAIT_RIGHT = 2'd1,
      FULL       = 2'd2
   } state_t;

   state_t                   state, state_nxt;
   logic [DIV_W-1:0]         div_cnt, div_nxt_c;
   logic [BIT_W-1:0]         bit_cnt, bit_nxt_c;
   logic [AUDIO_WIDTH_P-1:0] buf_l, buf_r;
   logic [FRAME_W-1:0]       shreg, frame_load_c;
   logic                     fall_c, bnd_c, accept_c;
   logic                     ready_nxt_c, store_l_c, store_r_c;
   logic                     load_c, under_c, sync_set_c;
`ifdef DAC_HOLD_ON_UNDERRUN_EN
   logic [FRAME_W-1:0]       last_frame;
`endif

   // Place a sample in its slot: one leading zero, MSB first, zero padding.
   function automatic logic [SLOT_WIDTH_P-1:0] slot_f(input logic [AUDIO_WIDTH_P-1:0] s);
      return {{PAD_W{1'b0}}, s} << (PAD_W - 1);
   endfunction

   // Timing strobes: SCLK falling edge, frame boundary, stream handshake.
   always_comb begin
      fall_c    = (div_cnt == DIV_W'(SCLK_DIV_P - 1));
      bnd_c     = fall_c && (bit_cnt == BIT_W'(FRAME_W - 1));
      accept_c  = dac_valid && dac_ready;
      div_nxt_c = fall_c ? '0 : div_cnt + 1'b1;
      bit_nxt_c = bnd_c ? '0 : bit_cnt + 1'b1;
   end

   // SCLK divider; SCLK is high for the upper half of the divide count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt  <= '0;
         i2s_sclk <= 1'b0;
      end else begin
         div_cnt  <= div_nxt_c;
         i2s_sclk <= (div_nxt_c >= DIV_W'(SCLK_DIV_P / 2));
      end
   end

   // Bit position within the frame, word select and frame strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt   <= '0;
         i2s_lrck  <= 1'b0;
         fs_strobe <= 1'b0;
      end else begin
         fs_strobe <= bnd_c;
         if (fall_c) begin
            bit_cnt  <= bit_nxt_c;
            i2s_lrck <= (bit_nxt_c >= BIT_W'(SLOT_WIDTH_P));
         end
      end
   end

   // Input FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= WAIT_LEFT;
      else        state <= state_nxt;
   end

   // Input FSM next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         WAIT_LEFT:  if (accept_c && !dac_last) state_nxt = WAIT_RIGHT;
         WAIT_RIGHT: if (accept_c && dac_last)  state_nxt = FULL;
         FULL:       if (bnd_c)                 state_nxt = WAIT_LEFT;
         default:                               state_nxt = WAIT_LEFT;
      endcase
   end

   // Input FSM decode; ready reopens one cycle after the buffer drains.
   always_comb begin
      ready_nxt_c = (state_nxt != FULL) && (state != FULL);
      store_l_c   = accept_c && !dac_last;
      store_r_c   = accept_c && dac_last && (state == WAIT_RIGHT);
      sync_set_c  = accept_c && dac_last && (state == WAIT_LEFT);
      load_c      = bnd_c && (state == FULL);
      under_c     = bnd_c && (state != FULL);
   end

   // Handshake register and one-frame sample buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dac_ready <= 1'b0;
         buf_l     <= '0;
         buf_r     <= '0;
      end else begin
         dac_ready <= ready_nxt_c;
         if (store_l_c) buf_l <= dac_data;
         if (store_r_c) buf_r <= dac_data;
      end
   end

   // Sticky status flags; a new error wins over a coincident clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_underrun <= 1'b0;
         sr_sync_err <= 1'b0;
      end else begin
         if (under_c)              sr_underrun <= 1'b1;
         else if (cmd_clear_flags) sr_underrun <= 1'b0;
         if (sync_set_c)           sr_sync_err <= 1'b1;
         else if (cmd_clear_flags) sr_sync_err <= 1'b0;
      end
   end

   // Frame to load at the boundary: buffered frame, or the underrun fill.
   always_comb begin
      frame_load_c = '0;
      if (load_c) frame_load_c = {slot_f(buf_l), slot_f(buf_r)};
`ifdef DAC_HOLD_ON_UNDERRUN_EN
      else        frame_load_c = last_frame;
`endif
   end

`ifdef DAC_HOLD_ON_UNDERRUN_EN
   // Remember the last real frame so it can be repeated on underrun.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      last_frame <= '0;
      else if (load_c) last_frame <= frame_load_c;
   end
`endif

   // Frame shift register, MSB out first on each SCLK falling edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg     <= '0;
         i2s_sdata <= 1'b0;
      end else if (bnd_c) begin
         shreg     <= frame_load_c;
         i2s_sdata <= frame_load_c[FRAME_W-1];
      end else if (fall_c) begin
         shreg     <= shreg << 1;
         i2s_sdata <= shreg[FRAME_W-2];
      end
   end

endmodule

// File: tb/tb_cs_dac_i2s_transmitter.sv
// Directed bench for cs_dac_i2s_transmitter (default parameters).
module tb_cs_dac_i2s_transmitter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [23:0] dac_data = '0;
   logic        dac_valid = 1'b0;
   logic        dac_ready;
   logic        dac_last = 1'b0;
   logic        cmd_clear_flags = 1'b0;
   logic        i2s_sclk, i2s_lrck, i2s_sdata, fs_strobe, sr_underrun, sr_sync_err;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int fs_cyc = 0;
   int rdy_cyc = 0;

   localparam logic [63:0] LR_EXP = 64'h00000000_FFFFFFFF;

   cs_dac_i2s_transmitter dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .dac_data        (dac_data),
      .dac_valid       (dac_valid),
      .dac_ready       (dac_ready),
      .dac_last        (dac_last),
      .cmd_clear_flags (cmd_clear_flags),
      .i2s_sclk        (i2s_sclk),
      .i2s_lrck        (i2s_lrck),
      .i2s_sdata       (i2s_sdata),
      .fs_strobe       (fs_strobe),
      .sr_underrun     (sr_underrun),
      .sr_sync_err     (sr_sync_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_fs();
      int n = 0;
      do begin
         tick();
         n++;
      end while (!fs_strobe && n < 2000);
      if (!fs_strobe) chk("fs_timeout", 64'd0, 64'd1);
      fs_cyc = cyc;
   endtask

   task automatic wait_rise();
      int   n = 0;
      logic p;
      do begin
         p = i2s_sclk;
         tick();
         n++;
      end while (!(!p && i2s_sclk) && n < 64);
      if (!(!p && i2s_sclk)) chk("sclk_timeout", 64'd0, 64'd1);
   endtask

   task automatic capture(output logic [63:0] d, output logic [63:0] lr);
      d  = '0;
      lr = '0;
      for (int k = 0; k < 64; k++) begin
         wait_rise();
         d[63-k]  = i2s_sdata;
         lr[63-k] = i2s_lrck;
      end
   endtask

   task automatic send(input logic [23:0] data, input logic last);
      int n = 0;
      dac_data  = data;
      dac_last  = last;
      dac_valid = 1'b1;
      while (!dac_ready && n < 3000) begin
         tick();
         n++;
      end
      if (!dac_ready) chk("ready_timeout", 64'd0, 64'd1);
      rdy_cyc = cyc;
      tick();
      dac_valid = 1'b0;
      dac_last  = 1'b0;
   endtask

   task automatic clear_flags();
      cmd_clear_flags = 1'b1;
      tick();
      cmd_clear_flags = 1'b0;
   endtask

   initial begin
      logic [63:0] d, lr, f1, f2, l1, l2, hold_exp;
      int n;

      // 1: reset values, ready latency, frame period
      repeat (10) tick();
      chk("reset_outputs", 64'({dac_ready, i2s_sclk, i2s_lrck, i2s_sdata,
                                fs_strobe, sr_underrun, sr_sync_err}), 64'd0);
      rst_n = 1'b1;
      n = 0;
      tick();
      n++;
      chk("ready_after_reset", 64'(dac_ready), 64'd1);
      while (!fs_strobe && n < 2000) begin
         tick();
         n++;
      end
      chk("first_fs_cycles", 64'(n), 64'd512);
      chk("underrun_first_boundary", 64'(sr_underrun), 64'd1);
      n = 0;
      do begin
         tick();
         n++;
      end while (!fs_strobe && n < 2000);
      chk("fs_period", 64'(n), 64'd512);
      clear_flags();
      chk("underrun_cleared", 64'(sr_underrun), 64'd0);

      // 2: one frame, full-scale patterns
      send(24'h800001, 1'b0);
      send(24'h7FFFFF, 1'b1);
      wait_fs();
      capture(d, lr);
      chk("frame_800001_7fffff", d, 64'h40000080_3FFFFF80);
      chk("lrck_pattern", lr, LR_EXP);
      chk("no_underrun_when_full", 64'(sr_underrun), 64'd0);

      // 3: underrun
`ifdef DAC_HOLD_ON_UNDERRUN_EN
      hold_exp = 64'h40000080_3FFFFF80;
`else
      hold_exp = 64'd0;
`endif
      wait_fs();
      capture(d, lr);
      chk("underrun_frame", d, hold_exp);
      chk("underrun_flag", 64'(sr_underrun), 64'd1);
      wait_fs();
      clear_flags();
      chk("underrun_clear", 64'(sr_underrun), 64'd0);

      // 4: back-pressure, two frames back to back
      fork
         begin
            wait_fs();
            capture(f1, l1);
            wait_fs();
            capture(f2, l2);
         end
         begin
            send(24'h000001, 1'b0);
            send(24'hFFFFFF, 1'b1);
            chk("ready_low_when_full", 64'(dac_ready), 64'd0);
            send(24'hA5A5A5, 1'b0);
            chk("ready_fs_plus_one", 64'(rdy_cyc - fs_cyc), 64'd1);
            send(24'h5A5A5A, 1'b1);
         end
      join
      chk("bp_frame1", f1, 64'h00000080_7FFFFF80);
      chk("bp_frame2", f2, 64'h52D2D280_2D2D2D00);
      chk("bp_lrck2", l2, LR_EXP);

      // 5: sync error then a clean pair
      wait_fs();
      chk("sync_err_idle", 64'(sr_sync_err), 64'd0);
      send(24'hABCDEF, 1'b1);
      chk("sync_err_set", 64'(sr_sync_err), 64'd1);
      chk("sync_err_still_ready", 64'(dac_ready), 64'd1);
      send(24'h123456, 1'b0);
      send(24'h654321, 1'b1);
      wait_fs();
      capture(d, lr);
      chk("frame_after_sync_err", d, 64'h091A2B00_32A19080);

      // 6: reset mid-frame discards the buffered frame
      wait_fs();
      send(24'hABCDEF, 1'b0);
      send(24'h111111, 1'b1);
      repeat (40) wait_rise();
      rst_n = 1'b0;
      #1;
      chk("midframe_reset_outputs", 64'({dac_ready, i2s_sclk, i2s_lrck, i2s_sdata,
                                         fs_strobe, sr_underrun, sr_sync_err}), 64'd0);
      repeat (5) tick();
      rst_n = 1'b1;
      wait_fs();
      capture(d, lr);
      chk("post_reset_frame_zero", d, 64'd0);
      chk("post_reset_underrun", 64'(sr_underrun), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
